// File: rtl/sqr_arbiter.sv
// sqr_arbiter: shares one combinational squarer between N_REQ requesters.
// Each granted operand is registered, squared in the following cycle and
// captured into a one-entry result buffer owned by the requester.
// Optional feature: define SQR_RR_EN for round-robin arbitration;
// otherwise the lowest eligible index wins (fixed priority).
module sqr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*LEN-1:0]      req_x,
  output logic [N_REQ-1:0]          resp_valid,
  input  logic [N_REQ-1:0]          resp_ready,
  output logic [N_REQ*2*LEN-1:0]    resp_y,
  output logic [LEN-1:0]            sq_x,
  input  logic [2*LEN-1:0]          sq_y,
  output logic                      busy
);

  localparam int unsigned TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [LEN-1:0]                    op_q, op_d;
  logic [TW-1:0]                     tag_q, tag_d;
  logic                              inflight_q, inflight_d;
  logic [N_REQ-1:0]                  rvalid_q, rvalid_d;
  logic [N_REQ-1:0][2*LEN-1:0]       buf_q, buf_d;

  logic [N_REQ-1:0]                  elig;
  logic                              gnt_any;
  logic [TW-1:0]                     gnt_idx;

  // Eligibility: requesting, no op of its own in flight, buffer free or draining now
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i]
              & ~(inflight_q & (tag_q == TW'(i)))
              & (~rvalid_q[i] | resp_ready[i]);
    end
  end

`ifdef SQR_RR_EN
  logic [TW-1:0] ptr_q, ptr_d;
  int unsigned   idx;

  // Round-robin search starting at the pointer, wrapping modulo N_REQ
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && elig[TW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = TW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (gnt_any && !rst) begin
      ptr_d = (gnt_idx == TW'(N_REQ - 1)) ? '0 : gnt_idx + TW'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest eligible index wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_any && elig[k]) begin
        gnt_any = 1'b1;
        gnt_idx = TW'(k);
      end
    end
  end
`endif

  // One-hot grant, suppressed while reset is asserted
  always_comb begin
    req_ready = '0;
    if (gnt_any && !rst) req_ready[gnt_idx] = 1'b1;
  end

  // Op register next state: latch operand and tag on grant
  always_comb begin
    op_d       = op_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (gnt_any) begin
      inflight_d = 1'b1;
      tag_d      = gnt_idx;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (gnt_idx == TW'(i)) op_d = req_x[i*LEN +: LEN];
      end
    end
  end

  // Result buffers: a refill wins over a pop in the same cycle
  always_comb begin
    rvalid_d = rvalid_q;
    buf_d    = buf_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (inflight_q && (tag_q == TW'(i))) begin
        buf_d[i]    = sq_y;
        rvalid_d[i] = 1'b1;
      end else if (rvalid_q[i] && resp_ready[i]) begin
        rvalid_d[i] = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      rvalid_q   <= '0;
      buf_q      <= '0;
    end else begin
      op_q       <= op_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      rvalid_q   <= rvalid_d;
      buf_q      <= buf_d;
    end
  end

  // Outputs
  always_comb begin
    sq_x       = op_q;
    resp_valid = rvalid_q;
    resp_y     = buf_q;
    busy       = inflight_q | (|rvalid_q);
  end

endmodule

// File: tb/tb_sqr_arbiter.sv
// Directed testbench for sqr_arbiter (N_REQ=4, LEN=16). The bench supplies
// the shared squarer as sq_y = sq_x * sq_x. Inputs change on the falling
// edge; outputs are sampled 1 time unit later.
module tb_sqr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned L = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*L-1:0]    req_x;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [N*2*L-1:0]  resp_y;
  logic [L-1:0]      sq_x;
  logic [2*L-1:0]    sq_y;
  logic              busy;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] sq_exp [4] = '{32'h0001_0000, 32'h0001_0201, 32'h0001_0404, 32'h0001_0609};

  sqr_arbiter #(.N_REQ(N), .LEN(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .sq_x       (sq_x),
    .sq_y       (sq_y),
    .busy       (busy)
  );

  assign sq_y = {16'h0, sq_x} * {16'h0, sq_x};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int e;
    int ep;

    rst        = 1'b1;
    req_valid  = 4'hF;
    resp_ready = 4'h0;
    req_x      = '0;

    // Reset state, with requests pending during reset
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ready", req_ready, 4'h0);
    check("rst_rvalid", resp_valid, 4'h0);
    check("rst_resp_y", resp_y, 64'h0);
    check("rst_sq_x", sq_x, 16'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b0; req_valid = 4'h0; #1;

    // Single op: requester 2, x = 3
    @(negedge clk); req_valid = 4'b0100; req_x[2*L +: L] = 16'h0003; #1;
    check("s_ready", req_ready, 4'b0100);
    @(negedge clk); req_valid = 4'h0; #1;
    check("s_sq_x", sq_x, 16'h0003);
    check("s_rvalid_early", resp_valid, 4'h0);
    check("s_busy", busy, 1'b1);
    @(negedge clk); #1;
    check("s_rvalid", resp_valid, 4'b0100);
    check("s_resp_y", resp_y[2*2*L +: 2*L], 32'h0000_0009);
    @(negedge clk); #1;
    check("s_hold_rvalid", resp_valid, 4'b0100);
    check("s_hold_y", resp_y[2*2*L +: 2*L], 32'h0000_0009);
    @(negedge clk); resp_ready = 4'b0100; #1;
    @(negedge clk); resp_ready = 4'h0; #1;
    check("s_pop", resp_valid, 4'h0);

    // Full-scale operand on requester 0
    @(negedge clk); req_valid = 4'b0001; req_x[0 +: L] = 16'hFFFF; #1;
    check("f_ready", req_ready, 4'b0001);
    @(negedge clk); req_valid = 4'h0; #1;
    check("f_sq_x", sq_x, 16'hFFFF);
    @(negedge clk); resp_ready = 4'b0001; #1;
    check("f_rvalid", resp_valid, 4'b0001);
    check("f_resp_y", resp_y[0 +: 2*L], 32'hFFFE_0001);
    @(negedge clk); resp_ready = 4'h0; #1;
    check("f_pop", resp_valid, 4'h0);
    check("f_idle", busy, 1'b0);

    // Backpressure: requester 1 holds a full buffer, requester 3 still served
    @(negedge clk); req_valid = 4'b0010; req_x[1*L +: L] = 16'd7; #1;
    check("b_ready1", req_ready, 4'b0010);
    @(negedge clk); req_valid = 4'h0; #1;
    @(negedge clk); req_valid = 4'b1010; req_x[1*L +: L] = 16'd8; req_x[3*L +: L] = 16'd10; #1;
    check("b_rvalid1", resp_valid, 4'b0010);
    check("b_y1", resp_y[1*2*L +: 2*L], 32'd49);
    check("b_ready3", req_ready, 4'b1000);
    @(negedge clk); req_valid = 4'b0010; #1;
    check("b_block_a", req_ready, 4'h0);
    @(negedge clk); #1;
    check("b_rvalid13", resp_valid, 4'b1010);
    check("b_block_b", req_ready, 4'h0);
    @(negedge clk); resp_ready = 4'b0010; #1;
    check("b_pop_gnt", req_ready, 4'b0010);
    @(negedge clk); req_valid = 4'h0; resp_ready = 4'h0; #1;
    check("b_popped", resp_valid, 4'b1000);
    check("b_sq_x", sq_x, 16'd8);
    @(negedge clk); #1;
    check("b_refill", resp_valid, 4'b1010);
    check("b_y1_new", resp_y[1*2*L +: 2*L], 32'd64);
    check("b_y3", resp_y[3*2*L +: 2*L], 32'd100);
    @(negedge clk); resp_ready = 4'hF; #1;
    @(negedge clk); resp_ready = 4'h0; #1;
    check("b_drain", resp_valid, 4'h0);
    check("b_idle", busy, 1'b0);

    // Reset in the cycle after a grant
    @(negedge clk); req_valid = 4'b0001; req_x[0 +: L] = 16'd5; #1;
    check("r_ready", req_ready, 4'b0001);
    @(negedge clk); rst = 1'b1; req_valid = 4'h0; #1;
    @(negedge clk); rst = 1'b0; #1;
    check("r_ready0", req_ready, 4'h0);
    check("r_rvalid0", resp_valid, 4'h0);
    check("r_resp_y0", resp_y, 64'h0);
    check("r_sq_x0", sq_x, 16'h0);
    check("r_busy0", busy, 1'b0);
    repeat (2) begin
      @(negedge clk); #1;
      check("r_no_stale", resp_valid, 4'h0);
      check("r_busy_after", busy, 1'b0);
    end

    // Contention: all requesters valid, responses always ready
    for (int i = 0; i < 4; i++) req_x[i*L +: L] = 16'h0100 + 16'(i);
    ep = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); req_valid = 4'hF; resp_ready = 4'hF; #1;
`ifdef SQR_RR_EN
      e = c % 4;
`else
      e = c % 2;
`endif
      check("c_grant", req_ready, 4'(1 << e));
      check("c_onehot", ($countones(req_ready) <= 1), 1'b1);
      if (c >= 2) begin
`ifdef SQR_RR_EN
        ep = (c - 2) % 4;
`else
        ep = (c - 2) % 2;
`endif
        check("c_rvalid", resp_valid, 4'(1 << ep));
        check("c_resp_y", resp_y[ep*2*L +: 2*L], sq_exp[ep]);
      end
    end
    @(negedge clk); req_valid = 4'h0; #1;
    repeat (2) @(negedge clk);
    #1;
    check("c_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
